// File: rtl/axis_cam_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_cam_core_if
//  Purpose  : Streaming request/response channel used on both sides of the
//             CAM core. One beat carries one complete request or response.
//  Ports    : valid/ready handshake, last (framing, one beat per message),
//             data {key, data} with the key in the MSBs, user (opcode on the
//             request side, status flags on the response side), id (tag).
//  Modports : master drives the payload, slave drives ready.
//  Revision : 1.0 - initial release
// ============================================================================
interface axis_cam_core_if #(
    parameter int DATA_WIDTH = 4,
    parameter int KEY_WIDTH  = 2,
    parameter int TID_WIDTH  = 4
);
    localparam int BUS_BITS = (KEY_WIDTH + DATA_WIDTH) * 8;

    logic                 valid;
    logic                 ready;
    logic                 last;
    logic [BUS_BITS-1:0]  data;
    logic [2:0]           user;
    logic [TID_WIDTH-1:0] id;

    modport master (
        output valid,
        output last,
        output data,
        output user,
        output id,
        input  ready
    );

    modport slave (
        input  valid,
        input  last,
        input  data,
        input  user,
        input  id,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/axis_cam_core.sv
`default_nettype none
// ============================================================================
//  Module   : axis_cam_core
//  Purpose  : Register-based content-addressable key/data table. Each request
//             beat (LOOKUP / INSERT / DELETE / CLEAR) produces exactly one
//             response beat. Key compare against all entries is parallel and
//             completes in a single cycle.
//  Ports    : i_clk        clock
//             i_rst        asynchronous active-high reset
//             s            request channel (slave): data={key,data},
//                          user=opcode, id=tag, last ignored
//             m            response channel (master): data={key,data},
//                          user={0,ERR,HIT}, id=echoed tag, last=1
//             o_occupancy  number of valid table entries
//  Revision : 1.0 - initial release
// ============================================================================
module axis_cam_core #(
    parameter int DATA_WIDTH = 4,
    parameter int KEY_WIDTH  = 2,
    parameter int TID_WIDTH  = 4,
    parameter int DEPTH      = 16
) (
    input  wire logic                       i_clk,
    input  wire logic                       i_rst,
    axis_cam_core_if.slave                  s,
    axis_cam_core_if.master                 m,
    output logic [$clog2(DEPTH+1)-1:0]      o_occupancy
);

    localparam int KEY_BITS  = KEY_WIDTH * 8;
    localparam int DATA_BITS = DATA_WIDTH * 8;
    localparam int BUS_BITS  = KEY_BITS + DATA_BITS;
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int OCC_W     = $clog2(DEPTH + 1);

    localparam logic [2:0] OP_LOOKUP = 3'd0;
    localparam logic [2:0] OP_INSERT = 3'd1;
    localparam logic [2:0] OP_DELETE = 3'd2;
    localparam logic [2:0] OP_CLEAR  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MATCH = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic                   ready_q;
    logic                   valid_q;

    // Captured request
    logic [KEY_BITS-1:0]    req_key_q;
    logic [DATA_BITS-1:0]   req_data_q;
    logic [2:0]             req_op_q;
    logic [TID_WIDTH-1:0]   req_id_q;

    // Table
    logic [DEPTH-1:0]       vld_q, vld_d;
    logic [KEY_BITS-1:0]    key_mem_q  [DEPTH];
    logic [DATA_BITS-1:0]   data_mem_q [DEPTH];
    logic [OCC_W-1:0]       occ_q, occ_d;

    // Response holding registers
    logic [BUS_BITS-1:0]    rsp_data_q, rsp_data_d;
    logic                   rsp_hit_q, rsp_hit_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [TID_WIDTH-1:0]   rsp_id_q, rsp_id_d;

    // Table write port (key and data always come from the captured request)
    logic                   tbl_we;
    logic [IDX_W-1:0]       tbl_idx;

    // Match results
    logic [DEPTH-1:0]       hit_vec;
    logic                   any_hit;
    logic                   any_free;
    logic [IDX_W-1:0]       hit_idx;
    logic [IDX_W-1:0]       free_idx;

    logic                   accept;

    // Every beat is a whole request, so framing is irrelevant here.
    logic                   unused_last;
    assign unused_last = s.last;

    assign accept = (state_q == ST_IDLE) && s.valid && ready_q;

    // ------------------------------------------------------------------
    // Parallel key compare
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_match
            assign hit_vec[g] = vld_q[g] && (key_mem_q[g] == req_key_q);
        end
    endgenerate

    // Lowest-index priority: scanning downward lets the smallest index win.
    always_comb begin
        any_hit  = 1'b0;
        any_free = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                any_hit = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!vld_q[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / table update logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        vld_d      = vld_q;
        occ_d      = occ_q;
        tbl_we     = 1'b0;
        tbl_idx    = free_idx;
        rsp_data_d = rsp_data_q;
        rsp_hit_d  = rsp_hit_q;
        rsp_err_d  = rsp_err_q;
        rsp_id_d   = rsp_id_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_MATCH;
                end
            end

            ST_MATCH: begin
                state_d    = ST_RESP;
                rsp_id_d   = req_id_q;
                rsp_hit_d  = 1'b0;
                rsp_err_d  = 1'b0;
                rsp_data_d = {req_key_q, {DATA_BITS{1'b0}}};

                case (req_op_q)
                    OP_LOOKUP: begin
                        if (any_hit) begin
                            rsp_hit_d  = 1'b1;
                            rsp_data_d = {req_key_q, data_mem_q[hit_idx]};
                        end
                    end

                    OP_INSERT: begin
                        rsp_data_d = {req_key_q, req_data_q};
                        if (any_hit) begin
                            // Existing key: overwrite in place, no new entry.
                            tbl_we    = 1'b1;
                            tbl_idx   = hit_idx;
                            rsp_hit_d = 1'b1;
                        end else if (any_free) begin
                            tbl_we          = 1'b1;
                            tbl_idx         = free_idx;
                            vld_d[free_idx] = 1'b1;
                            occ_d           = occ_q + OCC_W'(1);
                        end else begin
                            rsp_err_d = 1'b1;
                        end
                    end

                    OP_DELETE: begin
                        if (any_hit) begin
                            vld_d[hit_idx] = 1'b0;
                            occ_d          = occ_q - OCC_W'(1);
                            rsp_hit_d      = 1'b1;
                            rsp_data_d     = {req_key_q, data_mem_q[hit_idx]};
                        end
                    end

                    OP_CLEAR: begin
                        vld_d = '0;
                        occ_d = '0;
                    end

                    default: begin
                        rsp_err_d = 1'b1;
                    end
                endcase
            end

            ST_RESP: begin
                // Response registers only change in MATCH, so they stay
                // stable for as long as the consumer stalls.
                if (valid_q && m.ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            vld_q      <= '0;
            occ_q      <= '0;
            req_key_q  <= '0;
            req_data_q <= '0;
            req_op_q   <= '0;
            req_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            // Registered handshake flags track the state being entered, so
            // ready rises the cycle after a response handshake.
            ready_q    <= (state_d == ST_IDLE);
            valid_q    <= (state_d == ST_RESP);
            vld_q      <= vld_d;
            occ_q      <= occ_d;
            rsp_data_q <= rsp_data_d;
            rsp_hit_q  <= rsp_hit_d;
            rsp_err_q  <= rsp_err_d;
            rsp_id_q   <= rsp_id_d;
            if (accept) begin
                req_key_q  <= s.data[BUS_BITS-1:DATA_BITS];
                req_data_q <= s.data[DATA_BITS-1:0];
                req_op_q   <= s.user;
                req_id_q   <= s.id;
            end
        end
    end

    // Entry contents are qualified by vld_q, so they need no reset.
    always_ff @(posedge i_clk) begin
        if (tbl_we) begin
            key_mem_q[tbl_idx]  <= req_key_q;
            data_mem_q[tbl_idx] <= req_data_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s.ready     = ready_q;
    assign m.valid     = valid_q;
    assign m.last      = valid_q;
    assign m.data      = rsp_data_q;
    assign m.user      = {1'b0, rsp_err_q, rsp_hit_q};
    assign m.id        = rsp_id_q;
    assign o_occupancy = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_cam_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_cam_core
//  Purpose  : Directed self-checking bench for axis_cam_core.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_cam_core;

    logic       clk;
    logic       rst;
    logic [4:0] occ;

    int checks = 0;
    int errors = 0;

    logic [47:0] rsp_data;
    logic [2:0]  rsp_user;
    logic [3:0]  rsp_id;

    axis_cam_core_if #(.DATA_WIDTH(4), .KEY_WIDTH(2), .TID_WIDTH(4)) s_if ();
    axis_cam_core_if #(.DATA_WIDTH(4), .KEY_WIDTH(2), .TID_WIDTH(4)) m_if ();

    axis_cam_core #(
        .DATA_WIDTH (4),
        .KEY_WIDTH  (2),
        .TID_WIDTH  (4),
        .DEPTH      (16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .s           (s_if),
        .m           (m_if),
        .o_occupancy (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] bus(input logic [15:0] key, input logic [31:0] data);
        return {16'h0, key, data};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and wait for it to be accepted (bounded).
    task automatic present(input logic [2:0] op, input logic [15:0] key,
                           input logic [31:0] data, input logic [3:0] id);
        int n;
        n = 0;
        s_if.valid = 1'b1;
        s_if.user  = op;
        s_if.data  = {key, data};
        s_if.id    = id;
        s_if.last  = 1'b1;
        while (!s_if.ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept_wait", 64'(n < 20), 64'd1);
        tick();
    endtask

    // Full transaction with m_ready held high; captures the response beat.
    task automatic send(input logic [2:0] op, input logic [15:0] key,
                        input logic [31:0] data, input logic [3:0] id);
        present(op, key, data, id);
        s_if.valid = 1'b0;
        chk("match_cycle_valid", 64'(m_if.valid), 64'd0);
        tick();
        chk("latency2_valid", 64'(m_if.valid), 64'd1);
        chk("id_echo", 64'(m_if.id), 64'(id));
        chk("last", 64'(m_if.last), 64'd1);
        rsp_data = m_if.data;
        rsp_user = m_if.user;
        rsp_id   = m_if.id;
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        s_if.data  = '0;
        s_if.user  = '0;
        s_if.id    = '0;
        m_if.ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_s_ready", 64'(s_if.ready), 64'd0);
        chk("rst_m_valid", 64'(m_if.valid), 64'd0);
        chk("rst_m_data", 64'(m_if.data), 64'd0);
        chk("rst_m_user", 64'(m_if.user), 64'd0);
        chk("rst_m_id", 64'(m_if.id), 64'd0);
        chk("rst_m_last", 64'(m_if.last), 64'd0);
        chk("rst_occ", 64'(occ), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_s_ready", 64'(s_if.ready), 64'd1);

        // ---------------- lookup on empty table ----------------
        send(3'd0, 16'h1234, 32'h0, 4'd3);
        chk("lk_empty_user", 64'(rsp_user), 64'd0);
        chk("lk_empty_data", 64'(rsp_data), bus(16'h1234, 32'h0));
        chk("lk_empty_id", 64'(rsp_id), 64'd3);

        // ---------------- insert then lookup ----------------
        send(3'd1, 16'h1234, 32'hDEADBEEF, 4'd1);
        chk("ins_new_user", 64'(rsp_user), 64'd0);
        chk("ins_new_data", 64'(rsp_data), bus(16'h1234, 32'hDEADBEEF));
        chk("ins_new_occ", 64'(occ), 64'd1);
        send(3'd0, 16'h1234, 32'h0, 4'd2);
        chk("lk_hit_user", 64'(rsp_user), 64'd1);
        chk("lk_hit_data", 64'(rsp_data), bus(16'h1234, 32'hDEADBEEF));

        // ---------------- overwrite existing key ----------------
        send(3'd1, 16'h1234, 32'h11111111, 4'd4);
        chk("ins_ovr_user", 64'(rsp_user), 64'd1);
        chk("ins_ovr_occ", 64'(occ), 64'd1);
        send(3'd0, 16'h1234, 32'h0, 4'd5);
        chk("lk_ovr_data", 64'(rsp_data), bus(16'h1234, 32'h11111111));

        // ---------------- fill the table (index 0 holds 0x1234) ----------------
        for (int i = 1; i < 16; i++) begin
            send(3'd1, 16'h1000 + 16'(i), 32'hA0000000 + 32'(i), 4'(i));
            chk("fill_user", 64'(rsp_user), 64'd0);
            chk("fill_occ", 64'(occ), 64'(i + 1));
        end
        send(3'd1, 16'h2000, 32'hBBBBBBBB, 4'd6);
        chk("full_user", 64'(rsp_user), 64'd2);
        chk("full_occ", 64'(occ), 64'd16);
        send(3'd0, 16'h2000, 32'h0, 4'd6);
        chk("full_not_written", 64'(rsp_user), 64'd0);

        // delete entry at index 5
        send(3'd2, 16'h1005, 32'h0, 4'd7);
        chk("del_user", 64'(rsp_user), 64'd1);
        chk("del_data", 64'(rsp_data), bus(16'h1005, 32'hA0000005));
        chk("del_occ", 64'(occ), 64'd15);
        send(3'd0, 16'h1005, 32'h0, 4'd7);
        chk("del_gone", 64'(rsp_user), 64'd0);

        // re-insert into the freed slot
        send(3'd1, 16'h2000, 32'hBBBBBBBB, 4'd8);
        chk("reins_user", 64'(rsp_user), 64'd0);
        chk("reins_occ", 64'(occ), 64'd16);
        send(3'd1, 16'h3000, 32'hCCCCCCCC, 4'd9);
        chk("full_again_user", 64'(rsp_user), 64'd2);

        // ---------------- backpressure ----------------
        m_if.ready = 1'b0;
        present(3'd0, 16'h1003, 32'h0, 4'd7);
        // keep s_valid high with a second request queued behind
        s_if.data = {16'h2000, 32'h0};
        s_if.id   = 4'd8;
        chk("bp_match_sready", 64'(s_if.ready), 64'd0);
        tick();
        chk("bp_valid", 64'(m_if.valid), 64'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_hold_valid", 64'(m_if.valid), 64'd1);
            chk("bp_hold_data", 64'(m_if.data), bus(16'h1003, 32'hA0000003));
            chk("bp_hold_user", 64'(m_if.user), 64'd1);
            chk("bp_hold_id", 64'(m_if.id), 64'd7);
            chk("bp_hold_sready", 64'(s_if.ready), 64'd0);
        end
        m_if.ready = 1'b1;
        tick();
        chk("bp_rel_valid", 64'(m_if.valid), 64'd0);
        chk("bp_rel_sready", 64'(s_if.ready), 64'd1);
        tick();
        s_if.valid = 1'b0;
        chk("bp_2nd_accepted", 64'(s_if.ready), 64'd0);
        chk("bp_2nd_match", 64'(m_if.valid), 64'd0);
        tick();
        chk("bp_2nd_valid", 64'(m_if.valid), 64'd1);
        chk("bp_2nd_id", 64'(m_if.id), 64'd8);
        chk("bp_2nd_data", 64'(m_if.data), bus(16'h2000, 32'hBBBBBBBB));
        chk("bp_2nd_user", 64'(m_if.user), 64'd1);
        tick();
        chk("bp_2nd_done", 64'(m_if.valid), 64'd0);

        // ---------------- illegal opcode ----------------
        send(3'd5, 16'h1003, 32'h55555555, 4'd10);
        chk("illegal_user", 64'(rsp_user), 64'd2);
        chk("illegal_data", 64'(rsp_data), bus(16'h1003, 32'h0));
        chk("illegal_occ", 64'(occ), 64'd16);
        send(3'd0, 16'h1003, 32'h0, 4'd10);
        chk("illegal_kept", 64'(rsp_data), bus(16'h1003, 32'hA0000003));

        // ---------------- delete miss ----------------
        send(3'd2, 16'h7777, 32'h12345678, 4'd11);
        chk("del_miss_user", 64'(rsp_user), 64'd0);
        chk("del_miss_data", 64'(rsp_data), bus(16'h7777, 32'h0));
        chk("del_miss_occ", 64'(occ), 64'd16);

        // ---------------- clear ----------------
        send(3'd3, 16'hABCD, 32'hFFFFFFFF, 4'd9);
        chk("clr_user", 64'(rsp_user), 64'd0);
        chk("clr_data", 64'(rsp_data), bus(16'hABCD, 32'h0));
        chk("clr_occ", 64'(occ), 64'd0);
        send(3'd0, 16'h1234, 32'h0, 4'd12);
        chk("clr_lk_user", 64'(rsp_user), 64'd0);
        chk("clr_lk_data", 64'(rsp_data), bus(16'h1234, 32'h0));

        // ---------------- reset during MATCH ----------------
        send(3'd1, 16'h4444, 32'h44444444, 4'd13);
        chk("pre_rst_occ", 64'(occ), 64'd1);
        present(3'd1, 16'h5555, 32'h55555555, 4'd14);
        rst        = 1'b1;
        s_if.valid = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_if.valid), 64'd0);
        chk("mid_rst_occ", 64'(occ), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_rst_hold_valid", 64'(m_if.valid), 64'd0);
        end
        rst = 1'b0;
        send(3'd0, 16'h4444, 32'h0, 4'd15);
        chk("post_rst_lk", 64'(rsp_user), 64'd0);
        chk("post_rst_occ", 64'(occ), 64'd0);
        send(3'd0, 16'h5555, 32'h0, 4'd15);
        chk("post_rst_dropped", 64'(rsp_user), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_cam_core.md
Name: axis_cam_core

Overview:
- Content-addressable key/data table that consumes request beats carried on an axis_cam_if-shaped channel and returns one response beat per request on a second channel of the same shape.
- Sits directly downstream of the request producers. Requests are lookup, insert, delete or clear, selected by the user field; the id field is echoed so callers can route responses.
- Table is DEPTH entries of registers. Key match is fully parallel and takes one cycle.

Parameters:
- DATA_WIDTH, 4, data payload width in bytes (bus width DATA_WIDTH*8).
- KEY_WIDTH, 2, key width in bytes (bus width KEY_WIDTH*8).
- TID_WIDTH, 4, transaction id width in bits.
- DEPTH, 16, number of table entries; must be >= 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- s_valid  in  1  request valid.
- s_ready  out  1  request ready.
- s_last  in  1  request last; ignored, every beat is one request.
- s_data  in  (KEY_WIDTH+DATA_WIDTH)*8  request {key, data}, key in the MSBs.
- s_user  in  3  opcode: 0 LOOKUP, 1 INSERT, 2 DELETE, 3 CLEAR, 4-7 illegal.
- s_id  in  TID_WIDTH  request id.
- m_valid  out  1  response valid.
- m_ready  in  1  response ready.
- m_last  out  1  always 1 while m_valid.
- m_data  out  (KEY_WIDTH+DATA_WIDTH)*8  response {key, data}.
- m_user  out  3  bit0 HIT, bit1 ERR, bit2 always 0.
- m_id  out  TID_WIDTH  echoed request id.
- o_occupancy  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Interface: one clock i_clk; reset i_rst is asynchronous and active-high.
- Reset values:
  - s_ready=0 while in reset, then 1 in IDLE.
  - m_valid=0; m_data, m_user, m_id =0; m_last=0.
  - o_occupancy=0; all entry valid bits cleared. Entry key/data contents are don't-care.
- FSM states: IDLE, MATCH, RESP.
  - IDLE: s_ready=1. On s_valid&&s_ready, capture data/user/id and go to MATCH.
  - MATCH: s_ready=0. Compute hit vector (valid & key equal) for all entries and the lowest free index. Perform the table update, load the response registers, go to RESP.
  - RESP: m_valid=1, outputs held stable until m_ready. On m_valid&&m_ready, go to IDLE, and s_ready=1 on the next cycle.
- Latency: request accepted at cycle N, m_valid high at N+2. Peak throughput is one request per 3 cycles.
- LOOKUP:
  - hit: HIT=1, data=stored data.
  - miss: HIT=0, data=0.
  - Table unchanged.
- INSERT:
  - key present: overwrite data in place, HIT=1, occupancy unchanged.
  - key absent and a free slot exists: write the lowest free index, HIT=0, occupancy+1.
  - key absent and table full: no write, ERR=1.
  - Response data echoes the request data.
- DELETE:
  - hit: clear the valid bit, HIT=1, response data=removed data, occupancy-1.
  - miss: HIT=0, data=0.
- CLEAR: invalidate all entries, occupancy=0. Response HIT=0, ERR=0, data=0.
- Illegal opcode: no table change; ERR=1, HIT=0, data=0.
- Response key always echoes the request key. m_id always echoes s_id.
- Duplicate keys cannot arise because INSERT updates existing keys. If multiple hits are ever present, the lowest index wins.
- Occupancy never wraps: it saturates naturally at 0..DEPTH by construction.
- Backpressure: m_ready low holds RESP indefinitely. No further request is accepted, and the table is frozen.
- Reset asserted mid-transaction: the in-flight request is dropped, no response is produced, and the table is empty after reset.

Test Plan:
- Reset, then LOOKUP key 0x1234 id 3 -> m_valid exactly 2 cycles after accept; m_user=0, m_data={0x1234,0}, m_id=3, m_last=1.
- INSERT 0x1234/0xDEADBEEF, then LOOKUP 0x1234 -> insert response HIT=0 and occupancy 1; lookup response HIT=1, data 0xDEADBEEF.
- INSERT 0x1234/0x11111111 over an existing key -> HIT=1, occupancy stays 1; a later lookup returns 0x11111111.
- Fill 16 distinct keys, then INSERT a 17th -> ERR=1, occupancy=16. DELETE key at index 5 -> HIT=1, old data returned, occupancy 15. Re-INSERT the 17th -> written at index 5, ERR=0.
- Hold m_ready=0 for 10 cycles with s_valid high -> m_* outputs stable, s_ready=0, no second accept. Release -> response handshake, then the next request is accepted one cycle later.
- Opcode 5 -> ERR=1, table unchanged. CLEAR -> occupancy 0, and a subsequent LOOKUP of any prior key misses. Assert i_rst during MATCH -> m_valid stays 0, occupancy 0.
